// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data RAM access controller.
package dmem_pkg;

    localparam int NUM_LANES = 4;
    localparam int BO_LITTLE = 0;
    localparam int BO_BIG    = 1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_e;

    // Reserved size behaves as a word access.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] ofs);
        case (mem_size_e'(size))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return ofs[0];
            default: return ofs != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side and RAM-side signals of the data memory access controller.
interface dmem_access_ctrl_if #(parameter int ADDR_W = 14);

    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic              mem_unsigned;
    logic [31:0]       address;
    logic [31:0]       store_data;
    logic [31:0]       load_data;
    logic              stall;
    logic              addr_err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    modport slave (
        input  mem_read, mem_write, mem_size, mem_unsigned, address, store_data, ram_dout,
        output load_data, stall, addr_err, ram_addr, ram_we, ram_din
    );

    modport master (
        output mem_read, mem_write, mem_size, mem_unsigned, address, store_data, ram_dout,
        input  load_data, stall, addr_err, ram_addr, ram_we, ram_din
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: sub-word store merge into a RAM word and load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int BYTE_ORDER = BO_LITTLE
) (
    input  logic [31:0] word,
    input  logic [31:0] st_data,
    input  logic [1:0]  size,
    input  logic [1:0]  ofs,
    input  logic        ld_unsigned,
    output logic [31:0] new_word,
    output logic [31:0] ld_data
);

    logic [1:0]           byte_lane;
    logic                 half_lane;
    logic [NUM_LANES-1:0] wmask;
    logic [31:0]          rep;
    logic [31:0]          b_sh;
    logic [31:0]          h_sh;

    // Big-endian mirrors the lane index: 3-ofs for bytes, 1-ofs[1] for halves.
    assign byte_lane = (BYTE_ORDER == BO_BIG) ? ~ofs    : ofs;
    assign half_lane = (BYTE_ORDER == BO_BIG) ? ~ofs[1] : ofs[1];

    always_comb begin
        wmask = 4'b1111;
        rep   = st_data;
        case (mem_size_e'(size))
            SZ_BYTE: begin
                wmask = 4'b0001 << byte_lane;
                rep   = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                wmask = half_lane ? 4'b1100 : 4'b0011;
                rep   = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign new_word[8*i +: 8] = wmask[i] ? rep[8*i +: 8] : word[8*i +: 8];
    end

    assign b_sh = word >> {byte_lane, 3'b000};
    assign h_sh = word >> {half_lane, 4'b0000};

    always_comb begin
        ld_data = word;
        case (mem_size_e'(size))
            SZ_BYTE: ld_data = {{24{~ld_unsigned & b_sh[7]}},  b_sh[7:0]};
            SZ_HALF: ld_data = {{16{~ld_unsigned & h_sh[15]}}, h_sh[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data RAM sequencer: pass-through word accesses, 2-cycle RMW for
// byte/half stores, load extraction, and misaligned-access suppression.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int BYTE_ORDER = BO_LITTLE
) (
    input  logic               clk,
    input  logic               rst,
    dmem_access_ctrl_if.slave  bus
);

    state_e      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] new_word;
    logic [31:0] ld_ext;
    logic        access;
    logic        misaligned;
    logic        is_word;
    logic        stall;
    logic        ram_we;
    logic        addr_err;
    logic [31:0] ram_din;
    logic        unused_addr;

    assign access      = bus.mem_read | bus.mem_write;
    assign misaligned  = is_misaligned(bus.mem_size, bus.address[1:0]);
    assign is_word     = bus.mem_size[1];
    assign unused_addr = ^{bus.address[31:ADDR_W+2]};

    dmem_lane_align #(.BYTE_ORDER(BYTE_ORDER)) u_align (
        .word        (bus.ram_dout),
        .st_data     (bus.store_data),
        .size        (bus.mem_size),
        .ofs         (bus.address[1:0]),
        .ld_unsigned (bus.mem_unsigned),
        .new_word    (new_word),
        .ld_data     (ld_ext)
    );

    always_comb begin
        state_d  = state_q;
        merge_d  = merge_q;
        stall    = 1'b0;
        ram_we   = 1'b0;
        addr_err = 1'b0;
        ram_din  = bus.store_data;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    addr_err = access & misaligned;
                    if (bus.mem_write && !misaligned) begin
                        if (is_word) begin
                            ram_we = 1'b1;
                        end else begin
                            // Read half of the RMW: the RAM returns the old word this cycle.
                            stall   = 1'b1;
                            merge_d = new_word;
                            state_d = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    ram_we  = 1'b1;
                    ram_din = merge_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

    assign bus.ram_addr  = bus.address[ADDR_W+1:2];
    assign bus.ram_we    = ram_we;
    assign bus.ram_din   = ram_din;
    assign bus.stall     = stall;
    assign bus.addr_err  = addr_err;
    assign bus.load_data = misaligned ? 32'h0 : ld_ext;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench: little- and big-endian controllers share one stimulus stream,
// each backed by its own RAM; a byte-addressed reference model predicts every cycle.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    always #5 clk = ~clk;

    logic        mr, mw, mu;
    logic [1:0]  msz;
    logic [31:0] maddr, mdata;

    dmem_access_ctrl_if #(.ADDR_W(AW)) bus_le();
    dmem_access_ctrl_if #(.ADDR_W(AW)) bus_be();

    dmem_access_ctrl #(.ADDR_W(AW), .BYTE_ORDER(BO_LITTLE)) u_le (.clk(clk), .rst(rst), .bus(bus_le.slave));
    dmem_access_ctrl #(.ADDR_W(AW), .BYTE_ORDER(BO_BIG))    u_be (.clk(clk), .rst(rst), .bus(bus_be.slave));

    assign bus_le.mem_read = mr;  assign bus_be.mem_read = mr;
    assign bus_le.mem_write = mw; assign bus_be.mem_write = mw;
    assign bus_le.mem_size = msz; assign bus_be.mem_size = msz;
    assign bus_le.mem_unsigned = mu; assign bus_be.mem_unsigned = mu;
    assign bus_le.address = maddr; assign bus_be.address = maddr;
    assign bus_le.store_data = mdata; assign bus_be.store_data = mdata;

    function automatic logic [31:0] seed_word(int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // RAM behaves as write-at-clock-edge, read-through within the cycle.
    logic [31:0] ram [2][256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                ram[0][i] <= seed_word(i);
                ram[1][i] <= seed_word(i);
            end
        end else begin
            if (bus_le.ram_we) ram[0][bus_le.ram_addr[7:0]] <= bus_le.ram_din;
            if (bus_be.ram_we) ram[1][bus_be.ram_addr[7:0]] <= bus_be.ram_din;
        end
    end
    assign bus_le.ram_dout = ram[0][bus_le.ram_addr[7:0]];
    assign bus_be.ram_dout = ram[1][bus_be.ram_addr[7:0]];

    // Reference model: memory seen as bytes; e selects which word bits byte k occupies.
    logic [31:0] ref_mem [2][256];

    function automatic int bpos(int e, int k);
        return e ? 8 * (3 - k) : 8 * k;
    endfunction

    function automatic logic [7:0] get_b(int e, logic [31:0] w, int k);
        return 8'(w >> bpos(e, k));
    endfunction

    function automatic logic [31:0] set_b(int e, logic [31:0] w, int k, logic [7:0] b);
        return (w & ~(32'hFF << bpos(e, k))) | ({24'h0, b} << bpos(e, k));
    endfunction

    function automatic logic [31:0] model_load(int e, logic [31:0] w, logic [1:0] sz, logic uns, logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        int k;
        if (sz == 2'd0) begin
            b = get_b(e, w, int'(a[1:0]));
            return uns ? {24'h0, b} : {{24{b[7]}}, b};
        end else if (sz == 2'd1) begin
            k = int'(a[1]) * 2;
            h = e ? {get_b(e, w, k), get_b(e, w, k + 1)} : {get_b(e, w, k + 1), get_b(e, w, k)};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] model_store(int e, logic [31:0] w, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        logic [31:0] r;
        int k;
        r = w;
        if (sz == 2'd0) begin
            r = set_b(e, r, int'(a[1:0]), d[7:0]);
        end else if (sz == 2'd1) begin
            k = int'(a[1]) * 2;
            r = set_b(e, r, k,     e ? d[15:8] : d[7:0]);
            r = set_b(e, r, k + 1, e ? d[7:0]  : d[15:8]);
        end else begin
            r = d;
        end
        return r;
    endfunction

    typedef struct {
        int              id;
        logic            stall;
        logic            we;
        logic            err;
        logic            ck_din;
        logic            ck_ld;
        logic [1:0][31:0] din;
        logic [1:0][31:0] ld;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   op_id  = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s op%0d: got %h expected %h", nm, id, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("le_stall", x.id, {31'h0, bus_le.stall},    {31'h0, x.stall});
            chk("be_stall", x.id, {31'h0, bus_be.stall},    {31'h0, x.stall});
            chk("le_we",    x.id, {31'h0, bus_le.ram_we},   {31'h0, x.we});
            chk("be_we",    x.id, {31'h0, bus_be.ram_we},   {31'h0, x.we});
            chk("le_err",   x.id, {31'h0, bus_le.addr_err}, {31'h0, x.err});
            chk("be_err",   x.id, {31'h0, bus_be.addr_err}, {31'h0, x.err});
            if (x.ck_din) begin
                chk("le_din", x.id, bus_le.ram_din, x.din[0]);
                chk("be_din", x.id, bus_be.ram_din, x.din[1]);
            end
            if (x.ck_ld) begin
                chk("le_load", x.id, bus_le.load_data, x.ld[0]);
                chk("be_load", x.id, bus_be.load_data, x.ld[1]);
            end
        end
    end

    function automatic exp_t blank(int id);
        exp_t x;
        x = '{default: 0};
        x.id = id;
        return x;
    endfunction

    // One pipeline access; a sub-word store occupies two cycles with inputs held.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] d, input logic rst_rmw);
        exp_t x;
        logic [1:0][31:0] nw;
        logic mis;
        int w;
        @(posedge clk); #1;
        mr = rd; mw = wr; msz = sz; mu = uns; maddr = a; mdata = d;
        op_id++;
        w   = int'(a[9:2]);
        mis = (sz == 2'd0) ? 1'b0 : (sz == 2'd1) ? a[0] : (a[1:0] != 2'b00);
        x   = blank(op_id);
        x.ck_ld = rd | wr;
        if (mis) begin
            x.err = rd | wr;
        end else begin
            for (int e = 0; e < 2; e++) begin
                x.ld[e] = model_load(e, ref_mem[e][w], sz, uns, a);
                nw[e]   = model_store(e, ref_mem[e][w], sz, a, d);
            end
            if (wr && sz[1]) begin
                x.we = 1'b1; x.ck_din = 1'b1; x.din = nw;
            end
            if (wr && !sz[1]) x.stall = 1'b1;
        end
        exp_q.push_back(x);
        if (!mis && wr) begin
            if (sz[1]) begin
                for (int e = 0; e < 2; e++) ref_mem[e][w] = nw[e];
            end else begin
                @(posedge clk); #1;
                rst = rst_rmw;
                x = blank(op_id);
                x.we = ~rst_rmw; x.ck_din = ~rst_rmw; x.din = nw;
                exp_q.push_back(x);
                if (!rst_rmw) begin
                    for (int e = 0; e < 2; e++) ref_mem[e][w] = nw[e];
                end else begin
                    @(posedge clk); #1;
                    rst = 1'b0; mr = 1'b0; mw = 1'b0;
                    exp_q.push_back(blank(op_id));
                end
            end
        end
    endtask

    task automatic reset_cycle(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
        @(posedge clk); #1;
        rst = 1'b1; mr = rd; mw = wr; msz = sz; mu = 1'b0; maddr = a; mdata = 32'hA5A5A5A5;
        op_id++;
        exp_q.push_back(blank(op_id));
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int sel;
        rst = 1'b1; preload = 1'b1;
        mr = 1'b0; mw = 1'b0; msz = 2'd0; mu = 1'b0; maddr = '0; mdata = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[0][i] = seed_word(i);
            ref_mem[1][i] = seed_word(i);
        end
        @(posedge clk); #1;
        preload = 1'b0;

        // Held in reset: no stall, write or error even with live requests.
        reset_cycle(1'b0, 1'b1, 2'd0, 32'h21);
        reset_cycle(1'b1, 1'b0, 2'd2, 32'h22);
        reset_cycle(1'b0, 1'b1, 2'd1, 32'h13);
        @(posedge clk); #1;
        rst = 1'b0;

        op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        op(1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
        op(0, 1, 2'd2, 0, 32'h20, 32'h11223344, 0);
        op(0, 1, 2'd0, 0, 32'h21, 32'h000000AA, 0);
        op(1, 0, 2'd2, 0, 32'h20, 32'h0, 0);
        op(0, 1, 2'd2, 0, 32'h40, 32'h8000F0FF, 0);
        op(1, 0, 2'd0, 0, 32'h40, 32'h0, 0);
        op(1, 0, 2'd0, 1, 32'h40, 32'h0, 0);
        op(1, 0, 2'd1, 0, 32'h42, 32'h0, 0);
        op(1, 0, 2'd1, 1, 32'h42, 32'h0, 0);
        op(0, 1, 2'd1, 0, 32'h13, 32'h0000BEEF, 0);
        op(1, 0, 2'd2, 0, 32'h22, 32'h0, 0);
        op(0, 1, 2'd3, 0, 32'h41, 32'h12345678, 0);
        op(0, 1, 2'd0, 0, 32'h30, 32'h000000C1, 0);
        op(0, 1, 2'd0, 0, 32'h31, 32'h000000D2, 0);
        op(1, 0, 2'd2, 0, 32'h30, 32'h0, 0);
        op(0, 1, 2'd2, 0, 32'h50, 32'h11223344, 0);
        op(0, 1, 2'd0, 0, 32'h51, 32'h000000AA, 1);
        op(1, 0, 2'd2, 0, 32'h50, 32'h0, 0);
        op(1, 1, 2'd1, 1, 32'h62, 32'h0000CAFE, 0);
        op(1, 0, 2'd2, 0, 32'h60, 32'h0, 0);
        op(0, 1, 2'd1, 0, 32'h70, 32'h00001234, 0);
        op(0, 1, 2'd2, 0, 32'h74, 32'h55667788, 0);
        op(1, 0, 2'd2, 0, 32'h70, 32'h0, 0);

        for (int n = 0; n < 400; n++) begin
            sz  = 2'($urandom_range(0, 3));
            a   = $urandom_range(0, 1023);
            sel = $urandom_range(0, 7);
            op(sel inside {1, 2, 6}, sel inside {3, 4, 5, 6}, sz, 1'($urandom_range(0, 1)), a, $urandom, 0);
        end

        @(posedge clk); #1;
        mr = 1'b0; mw = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        for (int e = 0; e < 2; e++)
            for (int i = 0; i < 256; i++)
                chk(e ? "be_ram" : "le_ram", i, ram[e][i], ref_mem[e][i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
